conv_window_gen: RTL and testbench

//  Parametrised KxK sliding-window generator between the pixel stream and the conv core.

---
 rtl/conv_window_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: KxK sliding-window generator for a raster pixel stream.
// Keeps K-1 previous lines of pixels and a KxK register window. It emits one
// packed window for each valid output position, in stride-1 or stride-2 mode,
// together with frame and line markers and a sticky line-length error flag.
module conv_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  input  logic                 frame_start_in,
  input  logic                 line_start_in,
  input  logic                 frame_end_in,
  input  logic                 stride2,
  output logic [K*K*PIX_W-1:0] win_out,
  output logic                 win_valid,
  output logic                 frame_start_out,
  output logic                 line_start_out,
  output logic                 frame_end_out,
  output logic                 line_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_KM1   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1   = RW'(K - 1);
  // Position of the last stride-2 window. With stride 2 the bottom-right
  // pixel is not necessarily a window position.
  localparam logic [CW-1:0] COL_LAST2 = CW'((K - 1) + ((IMG_W - K) / 2) * 2);
  localparam logic [RW-1:0] ROW_LAST2 = RW'((K - 1) + ((IMG_H - K) / 2) * 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            stride_q;
  logic            first_q;

  // Position of the current pixel after frame-start and line-start forcing.
  logic [RW-1:0]   pr;
  logic [CW-1:0]   pc;
  logic            accept;
  logic            start;
  logic            err_set;
  logic            win_ok;
  logic            end_pos;
  logic            last_win;
  logic            done;

  logic [PIX_W-1:0] lb_q    [K-1][IMG_W];
  logic [PIX_W-1:0] win_q   [K][K];
  logic [PIX_W-1:0] win_nxt [K][K];
  logic [K*K*PIX_W-1:0] win_flat;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pixel position resolution and window qualification.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    accept   = 1'b0;
    start    = 1'b0;
    pr       = row_q;
    pc       = col_q;
    err_set  = 1'b0;
    win_ok   = 1'b0;
    end_pos  = 1'b0;
    last_win = 1'b0;
    done     = 1'b0;

    if (pix_valid) begin
      if (frame_start_in) begin
        // A start pixel always begins a new frame at (0,0), even mid-frame.
        accept = 1'b1;
        start  = 1'b1;
        pr     = '0;
        pc     = '0;
      end else if (state_q != IDLE) begin
        accept = 1'b1;
        if (line_start_in) begin
          if (col_q != '0) begin
            // Short line: the new line starts early and the counters follow it.
            err_set = 1'b1;
            pr      = row_q + RW'(1);
            pc      = '0;
          end
        end else if ((col_q == '0) && (row_q != '0)) begin
          // Long line: a pixel arrived at the wrap point without a line start.
          err_set = 1'b1;
        end
      end
    end

    end_pos  = (pr == ROW_LAST) && (pc == COL_LAST);
    last_win = stride_q ? ((pr == ROW_LAST2) && (pc == COL_LAST2)) : end_pos;

    if (accept && !start) begin
      win_ok = (pr >= ROW_KM1) && (pc >= COL_KM1) &&
               (!stride_q || ((pr[0] == ROW_KM1[0]) && (pc[0] == COL_KM1[0])));
      done   = frame_end_in || end_pos;
    end

    if (accept) begin
      if (pc == COL_LAST) begin
        col_d = '0;
        row_d = pr + RW'(1);
      end else begin
        col_d = pc + CW'(1);
        row_d = pr;
      end

      if (start) begin
        state_d = FILL;
      end else if (done) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if ((state_q == FILL) && (row_d >= ROW_KM1)) begin
        state_d = STREAM;
      end
    end
  end

  // Next window: shift the window left and insert the new column. The new
  // column is the K-1 buffered pixels above, oldest line at the top, with pix_in below them.
  always_comb begin
    win_nxt = '{default: '0};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nxt[r][K-1] = lb_q[r][pc];
    end
    win_nxt[K-1][K-1] = pix_in;
  end

  // Pack the next window, r=0 top and c=0 left.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*PIX_W +: PIX_W] = win_nxt[r][c];
      end
    end
  end

  // Line buffers and window registers advance on every accepted pixel.
  // NOTE: this storage is deliberately left unreset. Rows are rewritten
  // before any window can use them, so reset logic would gain nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K - 2; j++) begin
        lb_q[j][pc] <= lb_q[j+1][pc];
      end
      lb_q[K-2][pc] <= pix_in;
      win_q         <= win_nxt;
    end
  end

  // Counters, frame bookkeeping, error flag and registered window outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q           <= '0;
      col_q           <= '0;
      stride_q        <= 1'b0;
      first_q         <= 1'b0;
      line_err        <= 1'b0;
      win_valid       <= 1'b0;
      frame_start_out <= 1'b0;
      line_start_out  <= 1'b0;
      frame_end_out   <= 1'b0;
      win_out         <= '0;
    end else begin
      row_q           <= row_d;
      col_q           <= col_d;
      win_valid       <= win_ok;
      frame_start_out <= win_ok && first_q;
      line_start_out  <= win_ok && (pc == COL_KM1);
      frame_end_out   <= win_ok && (last_win || frame_end_in);

      if (start) begin
        stride_q <= stride2;
        first_q  <= 1'b1;
        line_err <= 1'b0;
      end else begin
        if (err_set) begin
          line_err <= 1'b1;
        end
        if (win_ok) begin
          first_q <= 1'b0;
        end
      end

      if (win_ok) begin
        win_out <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen. An image-array
// reference model predicts every window when a pixel is driven. A monitor
// pops the predictions and compares them as the DUT emits windows.
module tb_conv_window_gen;

  localparam int PIX_W = 8;
  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int K     = 7;
  localparam int WW    = K * K * PIX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             frame_start_in;
  logic             line_start_in;
  logic             frame_end_in;
  logic             stride2;
  logic [WW-1:0]    win_out;
  logic             win_valid;
  logic             frame_start_out;
  logic             line_start_out;
  logic             frame_end_out;
  logic             line_err;

  conv_window_gen #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pix_in          (pix_in),
    .pix_valid       (pix_valid),
    .frame_start_in  (frame_start_in),
    .line_start_in   (line_start_in),
    .frame_end_in    (frame_end_in),
    .stride2         (stride2),
    .win_out         (win_out),
    .win_valid       (win_valid),
    .frame_start_out (frame_start_out),
    .line_start_out  (line_start_out),
    .frame_end_out   (frame_end_out),
    .line_err        (line_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WW-1:0] w;
    bit            fs;
    bit            ls;
    bit            fe;
    int            stamp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] img [IMG_H][IMG_W];
  bit         m_active = 0;
  bit         m_s2     = 0;
  bit         m_first  = 0;
  int         m_r      = 0;
  int         m_c      = 0;

  // Place the pixel in an image array. If its position completes a window,
  // read that window directly out of the image.
  task automatic model_pixel(input logic [7:0] p, input bit fs, input bit ls,
                             input bit fe, input bit s2);
    int   pr, pc, step;
    bit   done;
    exp_t e;
    if (fs) begin
      m_active = 1; m_s2 = s2; m_first = 1; pr = 0; pc = 0;
    end else if (!m_active) begin
      return;
    end else begin
      pr = m_r; pc = m_c;
      if (ls && m_c != 0) begin pr = m_r + 1; pc = 0; end
    end
    if (pr < IMG_H) img[pr][pc] = p;
    step = m_s2 ? 2 : 1;
    if (!fs && pr >= K-1 && pr < IMG_H && pc >= K-1 &&
        ((pr-(K-1)) % step) == 0 && ((pc-(K-1)) % step) == 0) begin
      e.w = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          e.w[(i*K+j)*PIX_W +: PIX_W] = img[pr-K+1+i][pc-K+1+j];
      e.fs    = m_first;
      e.ls    = (pc == K-1);
      e.fe    = fe || ((pr + step >= IMG_H) && (pc + step >= IMG_W));
      e.stamp = cyc;
      exp_q.push_back(e);
      m_first = 0;
    end
    done = !fs && (fe || (pr == IMG_H-1 && pc == IMG_W-1));
    if (pc == IMG_W-1) begin m_c = 0; m_r = pr + 1; end
    else begin m_c = pc + 1; m_r = pr; end
    if (done) m_active = 0;
  endtask

  // ---------------- monitor ----------------
  int            n_win = 0, n_fs = 0, n_ls = 0, n_fe = 0;
  int            win_idx = 0;
  logic [WW-1:0] first_win, sec_win;

  always @(negedge clk) begin
    exp_t e;
    if (win_valid) begin
      n_win++;
      if (frame_start_out) n_fs++;
      if (line_start_out)  n_ls++;
      if (frame_end_out)   n_fe++;
      if (frame_start_out) begin win_idx = 0; first_win = win_out; end
      else begin
        win_idx++;
        if (win_idx == 1) sec_win = win_out;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_win_valid", WW'(win_valid), '0);
      end else begin
        e = exp_q.pop_front();
        check("win_data", win_out, e.w);
        check("frame_start_out", WW'(frame_start_out), WW'(e.fs));
        check("line_start_out", WW'(line_start_out), WW'(e.ls));
        check("frame_end_out", WW'(frame_end_out), WW'(e.fe));
        check("win_latency", WW'(cyc), WW'(e.stamp + 1));
      end
    end else if (frame_start_out || line_start_out || frame_end_out) begin
      check("marker_without_valid", WW'({frame_start_out, line_start_out, frame_end_out}), '0);
    end
  end

  // ---------------- driver ----------------
  int gap_pct = 0;

  function automatic logic [7:0] ramp(input int r, input int c);
    return 8'(r * IMG_W + c);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 0; frame_start_in = 0; line_start_in = 0; frame_end_in = 0;
    end
  endtask

  // Optional invalid gap cycles carrying junk, then one valid pixel.
  task automatic px(input logic [7:0] p, input bit fs, input bit ls, input bit fe, input bit s2);
    int g;
    g = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && g < 8) begin
      @(negedge clk);
      pix_valid      = 0;
      pix_in         = 8'($urandom);
      frame_start_in = 1'($urandom);
      line_start_in  = 1'($urandom);
      frame_end_in   = 1'($urandom);
      stride2        = 1'($urandom);
      g++;
    end
    @(negedge clk);
    pix_valid      = 1;
    pix_in         = p;
    frame_start_in = fs;
    line_start_in  = ls;
    frame_end_in   = fe;
    stride2        = fs ? s2 : 1'($urandom);
    model_pixel(p, fs, ls, fe, s2);
  endtask

  // Raster frame. It stops before pixel (stop_r, stop_c) when that pixel is in range.
  task automatic run_frame(input bit s2, input bit rnd, input int stop_r, input int stop_c);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == stop_r && c == stop_c) return;
        px(rnd ? 8'($urandom) : ramp(r, c), (r == 0 && c == 0), (c == 0),
           (r == IMG_H-1 && c == IMG_W-1), s2);
      end
    end
  endtask

  int b_win, b_fs, b_ls, b_fe;
  task automatic snap();
    b_win = n_win; b_fs = n_fs; b_ls = n_ls; b_fe = n_fe;
  endtask

  task automatic check_counts(input string tag, input int w, input int fs, input int ls, input int fe);
    check({tag, "_windows"}, WW'(n_win - b_win), WW'(w));
    check({tag, "_frame_start_out"}, WW'(n_fs - b_fs), WW'(fs));
    check({tag, "_line_start_out"}, WW'(n_ls - b_ls), WW'(ls));
    check({tag, "_frame_end_out"}, WW'(n_fe - b_fe), WW'(fe));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_win_valid"}, WW'(win_valid), '0);
    check({tag, "_frame_start_out"}, WW'(frame_start_out), '0);
    check({tag, "_line_start_out"}, WW'(line_start_out), '0);
    check({tag, "_frame_end_out"}, WW'(frame_end_out), '0);
    check({tag, "_line_err"}, WW'(line_err), '0);
    check({tag, "_win_out"}, win_out, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; pix_in = 0; pix_valid = 0; frame_start_in = 0;
    line_start_in = 0; frame_end_in = 0; stride2 = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 0;
    idle(2);

    // 1: stride 1 ramp frame, no gaps
    snap();
    run_frame(0, 0, -1, -1);
    idle(4);
    check_counts("s1", 676, 1, 26, 1);
    check("s1_first_win_0", WW'(first_win[7:0]), WW'(8'h00));
    check("s1_first_win_48", WW'(first_win[48*PIX_W +: PIX_W]), WW'(8'hC6));

    // 2: stride 2 ramp frame
    snap();
    run_frame(1, 0, -1, -1);
    idle(4);
    check_counts("s2", 169, 1, 13, 1);
    check("s2_second_win_topleft", WW'(sec_win[7:0]), WW'(8'h02));

    // 3: stride 1 ramp frame with 50% gaps
    gap_pct = 50;
    snap();
    run_frame(0, 0, -1, -1);
    idle(4);
    check_counts("gaps", 676, 1, 26, 1);

    // Random pixel data, both strides, with lighter gaps
    gap_pct = 30;
    snap();
    run_frame(0, 1, -1, -1);
    run_frame(1, 1, -1, -1);
    idle(4);
    check_counts("rand", 676 + 169, 2, 26 + 13, 2);
    gap_pct = 0;

    // 4: short line 3, then a frame-start clear, then a long line
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IMG_W; c++)
        px(ramp(r, c), (r == 0 && c == 0), (c == 0), 0, 0);
    for (int c = 0; c < 30; c++) px(ramp(3, c), 0, (c == 0), 0, 0);
    for (int c = 0; c < 10; c++) px(ramp(4, c), 0, (c == 0), (c == 9), 0);
    idle(2);
    check("line_err_short", WW'(line_err), WW'(1));
    idle(5);
    check("line_err_sticky", WW'(line_err), WW'(1));
    px(8'h00, 1, 1, 0, 0);
    idle(1);
    check("line_err_cleared", WW'(line_err), '0);
    for (int c = 1; c < IMG_W; c++) px(ramp(0, c), 0, 0, 0, 0);
    for (int c = 0; c < IMG_W; c++) px(ramp(1, c), 0, (c == 0), 0, 0);
    idle(1);
    check("line_err_normal_lines", WW'(line_err), '0);
    px(8'h55, 0, 0, 0, 0);
    px(8'h66, 0, 0, 1, 0);
    idle(2);
    check("line_err_long", WW'(line_err), WW'(1));

    // 5: frame restart at (10,5)
    snap();
    run_frame(0, 0, 10, 5);
    run_frame(0, 0, -1, -1);
    idle(4);
    check_counts("abort", 104 + 676, 2, 4 + 26, 1);
    check("abort_line_err", WW'(line_err), '0);

    // 6: reset at (8,8), ignored pixels, then a full frame
    snap();
    run_frame(0, 0, 8, 8);
    @(negedge clk);
    pix_valid = 0; rst = 1;
    m_active = 0;
    @(negedge clk);
    rst = 0;
    check_outputs_zero("midreset");
    for (int i = 0; i < 40; i++) px(8'($urandom), 0, (i % IMG_W == 0), 0, 0);
    idle(3);
    check("ignored_no_windows", WW'(n_win - b_win), WW'(54));
    run_frame(0, 0, -1, -1);
    idle(5);
    check_counts("after_reset", 54 + 676, 2, 3 + 26, 1);
    check("scoreboard_drained", WW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
